// File: rtl/logic_arb_pkg.sv
// Shared definitions for the two-requester logic-unit arbiter.
// Holds the operation encoding, the FSM state encoding and the requester count.
package logic_arb_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

endpackage

// File: rtl/logic_op_unit.sv
// Shared combinational bitwise unit: y = a <op> b over the full width.
module logic_op_unit
  import logic_arb_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  // Select the bitwise function; no carries, so the result keeps WIDTH bits.
  always_comb begin
    y = a & b;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOR:  y = ~(a | b);
      default: y = a & b;
    endcase
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one bitwise logic unit between two requesters.
// The result is registered and held until the consumer takes it; a new
// request may be accepted in the same cycle the held result is consumed.
// Optional build macro LOGIC_ARB_PARITY_EN adds rsp_parity (even parity of
// the registered result).
module logic_unit_arbiter
  import logic_arb_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_ready,
  input  logic [1:0]         req0_op,
  input  logic [1:0]         req1_op,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
`ifdef LOGIC_ARB_PARITY_EN
  output logic               rsp_parity,
`endif
  output logic [WIDTH-1:0]   rsp_data
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_id_q, rsp_id_d;
  // Requester that wins when both are valid; flips to the other one on accept.
  logic             prio_q, prio_d;
`ifdef LOGIC_ARB_PARITY_EN
  logic             rsp_parity_q, rsp_parity_d;
`endif

  logic             free;
  logic             grant;
  logic             accept;
  op_e              sel_op;
  logic [WIDTH-1:0] sel_a, sel_b, unit_y;

  // Arbitration: pick the requester and steer its operands into the unit.
  always_comb begin
    free      = (state_q == ST_IDLE) || rsp_ready;
    grant     = (&req_valid) ? prio_q : ~req_valid[0];
    accept    = free && (|req_valid) && !rst;
    req_ready = '0;
    if (accept) req_ready[grant] = 1'b1;
    sel_op    = grant ? op_e'(req1_op) : op_e'(req0_op);
    sel_a     = grant ? req1_a : req0_a;
    sel_b     = grant ? req1_b : req0_b;
  end

  logic_op_unit #(.WIDTH(WIDTH)) u_op (
    .op (sel_op),
    .a  (sel_a),
    .b  (sel_b),
    .y  (unit_y)
  );

  // Next-state: capture on accept, drain to IDLE when consumed with nothing new.
  always_comb begin
    state_d    = state_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    prio_d     = prio_q;
`ifdef LOGIC_ARB_PARITY_EN
    rsp_parity_d = rsp_parity_q;
`endif
    if (accept) begin
      state_d    = ST_RESP;
      rsp_data_d = unit_y;
      rsp_id_d   = grant;
      prio_d     = ~grant;
`ifdef LOGIC_ARB_PARITY_EN
      rsp_parity_d = ^unit_y;
`endif
    end else if ((state_q == ST_RESP) && rsp_ready) begin
      state_d = ST_IDLE;
    end
  end

  // State and result registers; reset drops any held result immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rsp_data_q <= '0;
      rsp_id_q   <= 1'b0;
      prio_q     <= 1'b0;
`ifdef LOGIC_ARB_PARITY_EN
      rsp_parity_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
      prio_q     <= prio_d;
`ifdef LOGIC_ARB_PARITY_EN
      rsp_parity_q <= rsp_parity_d;
`endif
    end
  end

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
`ifdef LOGIC_ARB_PARITY_EN
  assign rsp_parity = rsp_parity_q;
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter with a reference model and a
// per-cycle compare process.
module tb_logic_unit_arbiter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [1:0]   req0_op, req1_op;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [W-1:0] rsp_data;
`ifdef LOGIC_ARB_PARITY_EN
  logic         rsp_parity;
`endif

  int checks = 0;
  int errors = 0;

  logic_unit_arbiter #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req0_op    (req0_op),
    .req1_op    (req1_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
`ifdef LOGIC_ARB_PARITY_EN
    .rsp_parity (rsp_parity),
`endif
    .rsp_data   (rsp_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a result slot (busy/data/id) and the requester owed the next tie.
  logic         m_busy;
  logic [W-1:0] m_data;
  logic         m_id;
  logic         m_owed;

  function automatic logic [W-1:0] calc(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  function automatic int winner();
    if (req_valid == 2'b11) return int'(m_owed);
    if (req_valid[0]) return 0;
    if (req_valid[1]) return 1;
    return -1;
  endfunction

  function automatic logic [1:0] exp_ready();
    int w;
    if (rst) return 2'b00;
    if (m_busy && !rsp_ready) return 2'b00;
    w = winner();
    if (w < 0) return 2'b00;
    return (w == 0) ? 2'b01 : 2'b10;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0; m_data <= '0; m_id <= 1'b0; m_owed <= 1'b0;
    end else if (exp_ready() != 2'b00) begin
      m_busy <= 1'b1;
      m_id   <= (winner() == 1);
      m_owed <= (winner() == 0);
      m_data <= (winner() == 1) ? calc(req1_op, req1_a, req1_b) : calc(req0_op, req0_a, req0_b);
    end else if (rsp_ready) begin
      m_busy <= 1'b0;
    end
  end

  // Compare DUT against the model every cycle, mid-period.
  always @(negedge clk) begin
    chk("req_ready", req_ready, exp_ready());
    if (rst) begin
      chk("rst_valid", rsp_valid, 1'b0);
    end else begin
      chk("rsp_valid", rsp_valid, m_busy);
      if (m_busy) begin
        chk("rsp_id", rsp_id, m_id);
        chk("rsp_data", rsp_data, m_data);
`ifdef LOGIC_ARB_PARITY_EN
        chk("rsp_parity", rsp_parity, ^m_data);
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 2'b11; rsp_ready = 1'b0;
    req0_op = 2'd0; req1_op = 2'd0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    #3;
    chk("reset_valid", rsp_valid, 1'b0);
    chk("reset_data", rsp_data, 32'h0);
    chk("reset_id", rsp_id, 1'b0);
    chk("reset_ready", req_ready, 2'b00);
    tick(); tick();
    rst = 1'b0; req_valid = 2'b00; rsp_ready = 1'b1;

    // Idle with rsp_ready high: nothing happens.
    tick(); tick(); tick();
    chk("idle_valid", rsp_valid, 1'b0);

    // Single XOR request from requester 0.
    req_valid = 2'b01; req0_op = 2'd2; req0_a = 32'hFFFF0000; req0_b = 32'h0F0F0F0F;
    #2 chk("single_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00; rsp_ready = 1'b0;
    #2;
    chk("single_valid", rsp_valid, 1'b1);
    chk("single_id", rsp_id, 1'b0);
    chk("single_data", rsp_data, 32'hF0F00F0F);

    // Backpressure for three cycles with both requesting; requester 1 carries NOR 0,0.
    req_valid = 2'b11; req1_op = 2'd3; req1_a = '0; req1_b = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      #2;
      chk("bp_ready", req_ready, 2'b00);
      chk("bp_data", rsp_data, 32'hF0F00F0F);
      chk("bp_valid", rsp_valid, 1'b1);
    end
    tick();
    rsp_ready = 1'b1;
    #2 chk("release_ready", req_ready, 2'b10);
    tick();
    req_valid = 2'b00; rsp_ready = 1'b0;
    #2;
    chk("nor_data", rsp_data, 32'hFFFFFFFF);
    chk("nor_id", rsp_id, 1'b1);
`ifdef LOGIC_ARB_PARITY_EN
    chk("nor_parity", rsp_parity, 1'b0);
`endif

    // Reset while a result is held.
    #1 rst = 1'b1; req_valid = 2'b11;
    #1;
    chk("midrst_valid", rsp_valid, 1'b0);
    chk("midrst_data", rsp_data, 32'h0);
    chk("midrst_ready", req_ready, 2'b00);
    tick();
    rst = 1'b0;

    // Contention: both valid, consumer always ready -> 0,1,0,1.
    req0_op = 2'd0; req0_a = 32'hFFFF0000; req0_b = 32'h0F0F0F0F;
    req1_op = 2'd1; req1_a = 32'hFFFF0000; req1_b = 32'h0F0F0F0F;
    req_valid = 2'b11; rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("cont_ready", req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
      if (i > 0) begin
        chk("cont_id", rsp_id, (i % 2 == 0) ? 1'b1 : 1'b0);
        chk("cont_data", rsp_data, (i % 2 == 0) ? 32'hFFFF0F0F : 32'h0F0F0000);
        chk("cont_valid", rsp_valid, 1'b1);
      end
      tick();
    end
    req_valid = 2'b00;
    #2;
    chk("cont_last_id", rsp_id, 1'b1);
    chk("cont_last_data", rsp_data, 32'hFFFF0F0F);

    // Drain and idle; pointer must still favour requester 0.
    tick(); tick(); tick();
    chk("idle2_valid", rsp_valid, 1'b0);
    req_valid = 2'b11;
    #2 chk("idle2_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/logic_unit_arbiter.md
LOGIC_UNIT_ARBITER -- requirements
Module: logic_unit_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port req_valid  input  2  per-requester request valid; bit i = requester i.
REQ-005 SHALL have port req_ready  output  2  per-requester accept; request i accepted when req_valid[i] and req_ready[i] are both high at clk edge.
REQ-006 SHALL have ports req0_op / req1_op  input  2  operation: 00 AND, 01 OR, 10 XOR, 11 NOR.
REQ-007 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  WIDTH  operands.
REQ-008 SHALL have port rsp_valid  output  1  result valid.
REQ-009 SHALL have port rsp_ready  input  1  consumer accepts result.
REQ-010 SHALL have port rsp_id  output  1  index of requester owning the result.
REQ-011 SHALL have port rsp_data  output  WIDTH  registered result.

Function
REQ-012 SHALL implement FSM states IDLE (unit free, no result) and RESP (result held, rsp_valid=1).
REQ-013 SHALL be "free" when state=IDLE, or state=RESP and rsp_ready=1.
REQ-014 SHALL assert at most one req_ready bit per cycle, only when free, only for the granted requester with req_valid high; req_ready SHALL be combinational.
REQ-015 SHALL grant round-robin: both valid -> requester not granted most recently; one valid -> that one.
REQ-016 SHALL, on accept, register op result into rsp_data, requester index into rsp_id, enter RESP; rsp_valid high the next cycle (latency 1).
REQ-017 SHALL hold rsp_data/rsp_id/rsp_valid stable in RESP until rsp_ready=1.
REQ-018 SHALL, in RESP with rsp_ready=1 and a grantable request, accept it same cycle and stay in RESP (back-to-back, one result per cycle).
REQ-019 SHALL, in RESP with rsp_ready=1 and no request, return to IDLE with rsp_valid low next cycle.
REQ-020 SHALL ignore rsp_ready in IDLE; SHALL update round-robin pointer only on accept.
REQ-021 SHALL compute results bitwise over full WIDTH; NOR = ~(a|b), no carry/width growth.

Reset
REQ-022 SHALL on rst=1 immediately force: state IDLE, rsp_valid 0, rsp_id 0, rsp_data 0, pointer favouring requester 0 first.
REQ-023 SHALL drop any held result when reset asserts mid-operation; no response replayed after release.
REQ-024 SHALL drive req_ready 0 while rst=1.

Configuration
REQ-025 SHALL support macro LOGIC_ARB_PARITY_EN: defined -> extra output rsp_parity (1 bit, registered with rsp_data, even parity = XOR-reduction of result, reset 0); undefined -> port absent, no parity logic.

Structure
REQ-026 SHALL place op encoding (2-bit enum AND/OR/XOR/NOR) and requester-count constant (2) in shared package logic_arb_pkg.
REQ-027 SHALL instantiate one combinational sub-module logic_op_unit (op, a, b -> y) for the shared unit; arbitration/FSM stay in the top.

Verification
REQ-028 SHALL test single request: req0 XOR a=0xFFFF0000 b=0x0F0F0F0F -> next cycle rsp_valid=1, rsp_id=0, rsp_data=0xF0F00F0F.
REQ-029 SHALL test contention: both valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1; one result per cycle.
REQ-030 SHALL test backpressure: rsp_ready=0 for 3 cycles after result -> rsp_data stable, req_ready=00 throughout, release on 4th cycle.
REQ-031 SHALL test NOR all-zero: a=0, b=0, op=11 -> rsp_data=0xFFFFFFFF (parity 0 when LOGIC_ARB_PARITY_EN).
REQ-032 SHALL test reset mid-RESP: rst pulse while rsp_valid=1 -> rsp_valid=0 asynchronously, next grant with both valid goes to requester 0.
REQ-033 SHALL test idle: rsp_ready=1, no req_valid -> state stays IDLE, rsp_valid=0, pointer unchanged.
